// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the iterative MIPS shift unit:
//   - R-type funct codes of the six shift instructions
//   - kind_t  : internal shift-kind encoding used by the datapath
//   - state_t : FSM state encoding of iterative_shift_unit
// Optional feature macro: ISU_ROTATE_EN (enables the rotate kind in the decoder
// and datapath; KIND_ROR stays in the encoding either way).
// -----------------------------------------------------------------------------
package shift_pkg;

  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;
  localparam logic [5:0] FUNCT_SRLV = 6'b000110;
  localparam logic [5:0] FUNCT_SRAV = 6'b000111;

  typedef enum logic [1:0] {
    KIND_SLL = 2'd0,
    KIND_SRL = 2'd1,
    KIND_SRA = 2'd2,
    KIND_ROR = 2'd3
  } kind_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_decode.sv
// -----------------------------------------------------------------------------
// shift_decode
// Combinational decoder from raw MIPS R-type fields to a shift kind and amount.
// Ports:
//   funct  [5:0]    R-type funct field
//   shamt  [SW-1:0] immediate shift amount (sll/srl/sra)
//   rs_amt [SW-1:0] low bits of rs, variable shift amount (sllv/srlv/srav)
//   rot             rotate qualifier, only honoured when ISU_ROTATE_EN is defined
//   kind            decoded shift kind
//   amount [SW-1:0] number of one-bit steps
//   legal           funct is one of the six shift instructions
// Optional feature macro: ISU_ROTATE_EN (srl/srlv with rot=1 -> rotate right).
// -----------------------------------------------------------------------------
module shift_decode
  import shift_pkg::*;
#(
  parameter int SW = 5
) (
  input  logic [5:0]    funct,
  input  logic [SW-1:0] shamt,
  input  logic [SW-1:0] rs_amt,
  input  logic          rot,
  output kind_t         kind,
  output logic [SW-1:0] amount,
  output logic          legal
);

`ifndef ISU_ROTATE_EN
  // Rotate is compiled out, so the qualifier has no effect.
  logic w_unused_rot;
  assign w_unused_rot = rot;
`endif

  always_comb begin
    kind   = KIND_SLL;
    amount = shamt;
    legal  = 1'b1;
    case (funct)
      FUNCT_SLL:  kind = KIND_SLL;
      FUNCT_SRA:  kind = KIND_SRA;
      FUNCT_SRL: begin
        kind = KIND_SRL;
`ifdef ISU_ROTATE_EN
        if (rot) kind = KIND_ROR;
`endif
      end
      FUNCT_SLLV: begin
        kind   = KIND_SLL;
        amount = rs_amt;
      end
      FUNCT_SRAV: begin
        kind   = KIND_SRA;
        amount = rs_amt;
      end
      FUNCT_SRLV: begin
        kind   = KIND_SRL;
        amount = rs_amt;
`ifdef ISU_ROTATE_EN
        if (rot) kind = KIND_ROR;
`endif
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/iterative_shift_unit.sv
// -----------------------------------------------------------------------------
// iterative_shift_unit
// Multi-cycle MIPS shift execution unit: decodes the shift class from raw
// instruction fields, then shifts the latched operand one bit per clock.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   request handshake (in_ready only in IDLE)
//   funct, shamt, rot     instruction fields
//   rs_val, rt_val        operands (rs_val[SW-1:0] = variable amount)
//   out_valid / out_ready result handshake
//   result                shifted value (rt_val unchanged when illegal)
//   illegal               funct was not a shift, qualified by out_valid
//   busy                  state is not IDLE
//   dbg_state             current FSM state for observation
// Handshake: a transfer happens on a rising edge where valid && ready; once
// valid is raised the producer holds it and its data until that edge, and the
// result side keeps out_valid/result frozen until out_ready is seen.
// Optional feature macro: ISU_ROTATE_EN (rotr/rotrv via the rot qualifier).
// Latency: accept at cycle T -> out_valid at T+1+k (T+1 for k=0 or illegal).
// -----------------------------------------------------------------------------
module iterative_shift_unit
  import shift_pkg::*;
#(
  parameter int N  = 32,
  parameter int SW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [5:0]    funct,
  input  logic [SW-1:0] shamt,
  input  logic          rot,
  input  logic [N-1:0]  rs_val,
  input  logic [N-1:0]  rt_val,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  result,
  output logic          illegal,
  output logic          busy,
  output state_t        dbg_state
);

  localparam logic [SW-1:0] CNT_ONE = SW'(1);

  state_t        r_state;
  kind_t         r_kind;
  logic [SW-1:0] r_cnt;
  logic [N-1:0]  r_data;
  logic          r_out_valid;
  logic          r_illegal;

  kind_t         w_kind;
  logic [SW-1:0] w_amount;
  logic          w_legal;
  logic [N-1:0]  w_step;
  logic          w_unused_rs_hi;

  // Only the low SW bits of rs carry a shift amount.
  assign w_unused_rs_hi = ^rs_val[N-1:SW];

  shift_decode #(.SW(SW)) u_decode (
    .funct  (funct),
    .shamt  (shamt),
    .rs_amt (rs_val[SW-1:0]),
    .rot    (rot),
    .kind   (w_kind),
    .amount (w_amount),
    .legal  (w_legal)
  );

  // One-bit step of the latched operand.
  always_comb begin
    w_step = r_data;
    case (r_kind)
      KIND_SLL: w_step = {r_data[N-2:0], 1'b0};
      KIND_SRL: w_step = {1'b0, r_data[N-1:1]};
      KIND_SRA: w_step = {r_data[N-1], r_data[N-1:1]};
`ifdef ISU_ROTATE_EN
      KIND_ROR: w_step = {r_data[0], r_data[N-1:1]};
`endif
      default:  w_step = r_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_kind      <= KIND_SLL;
      r_cnt       <= '0;
      r_data      <= '0;
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_data    <= rt_val;
            r_kind    <= w_kind;
            r_illegal <= ~w_legal;
            r_cnt     <= w_legal ? w_amount : '0;
            if (w_legal && (w_amount != '0)) begin
              r_state <= S_SHIFT;
            end else begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          r_data <= w_step;
          r_cnt  <= r_cnt - CNT_ONE;
          // Last step lands together with the move to DONE.
          if (r_cnt == CNT_ONE) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_illegal   <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_data;
  assign illegal   = r_illegal;
  assign dbg_state = r_state;

endmodule
